// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_ctrl_pkg
//  Purpose  : Shared types and defaults for the neural-net control blocks:
//             layer-input arbiter FSM encoding, requester ids, width defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package nn_ctrl_pkg;

  // Default datapath and grant-length settings for the layer input arbiter
  localparam int NN_IWIDTH  = 64;
  localparam int NN_MAXBEAT = 16;
  localparam int NN_CW      = 4;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  // Requester identity; value doubles as the data-steering select
  typedef enum logic {
    REQ_IN0 = 1'b0,
    REQ_IN1 = 1'b1
  } req_id_e;

  // Round-robin tie break: the requester that did not hold the last grant wins
  function automatic req_id_e tie_winner(input req_id_e last_grant);
    return (last_grant == REQ_IN0) ? REQ_IN1 : REQ_IN0;
  endfunction

endpackage : nn_ctrl_pkg
`default_nettype wire

// File: rtl/mux2to1_64bit.sv
`default_nettype none
// ============================================================================
//  Module   : mux2to1_64bit
//  Purpose  : Plain two-input word multiplexer (sel=0 -> in1, sel=1 -> in2).
//  Revision : 1.0 - initial release
// ============================================================================
module mux2to1_64bit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Pure combinational select
  assign out = sel ? in2 : in1;

endmodule : mux2to1_64bit
`default_nettype wire

// File: rtl/layer_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : layer_input_arbiter
//  Purpose  : Two-way packet arbiter feeding the shared layer input. Requester
//             0 is the pixel input path, requester 1 the hidden-layer feedback.
//             A grant lasts until a beat with last=1 or MAXBEAT beats have
//             moved; ties go to whichever requester was not served last.
//             The output is a single registered stage with valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module layer_input_arbiter
  import nn_ctrl_pkg::*;
#(
  parameter int IWIDTH  = NN_IWIDTH,
  parameter int MAXBEAT = NN_MAXBEAT,
  parameter int CW      = NN_CW
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 : pixel input path
  input  logic              in0_valid,
  input  logic              in0_last,
  input  logic [IWIDTH-1:0] in0_data,
  output logic              in0_ready,
  // requester 1 : hidden-layer feedback path
  input  logic              in1_valid,
  input  logic              in1_last,
  input  logic [IWIDTH-1:0] in1_data,
  output logic              in1_ready,
  // shared layer input
  output logic              out_valid,
  output logic              out_last,
  output logic [IWIDTH-1:0] out_data,
  input  logic              out_ready,
  // status
  output logic              sel,
  output logic              busy
);

  // Beat index at which a grant is force-released
  localparam logic [CW-1:0] c_last_beat = CW'(MAXBEAT - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e        state_q;
  req_id_e           last_grant_q;
  logic [CW-1:0]     beat_cnt_q;
  logic              sel_q;
  logic              busy_q;

  logic              out_valid_q;
  logic              out_valid_d;
  logic              out_last_q;
  logic              out_last_d;
  logic [IWIDTH-1:0] out_data_q;
  logic [IWIDTH-1:0] out_data_d;

  // --------------------------------------------------------------------------
  // Combinational handshake terms
  // --------------------------------------------------------------------------
  logic              w_out_free;
  logic              w_xfer;
  logic              w_xfer_last;
  logic              w_release;
  logic              w_any_req;
  req_id_e           w_pick;
  logic [IWIDTH-1:0] w_mux_data;

  // The output stage can take a beat when empty or being drained this cycle
  assign w_out_free = !out_valid_q || out_ready;

  // Only the granted requester ever sees ready; both stay low in IDLE
  assign in0_ready = (state_q == ARB_GRANT0) && w_out_free;
  assign in1_ready = (state_q == ARB_GRANT1) && w_out_free;

  assign w_xfer      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign w_xfer_last = sel_q ? in1_last : in0_last;

  // A grant ends on an explicit last beat or on the MAXBEAT-th beat
  assign w_release = w_xfer && (w_xfer_last || (beat_cnt_q == c_last_beat));

  // Requester chosen when leaving IDLE
  assign w_any_req = in0_valid || in1_valid;

  // Arbitration pick: single requester wins outright, a tie alternates
  always_comb begin
    w_pick = REQ_IN0;
    if (in0_valid && in1_valid) begin
      w_pick = tie_winner(last_grant_q);
    end else if (in1_valid) begin
      w_pick = REQ_IN1;
    end
  end

  // Data steering follows the current grant
  mux2to1_64bit #(
    .WIDTH (IWIDTH)
  ) u_data_mux (
    .in1 (in0_data),
    .in2 (in1_data),
    .sel (sel_q),
    .out (w_mux_data)
  );

  // --------------------------------------------------------------------------
  // Arbitration FSM with beat counter and registered sel/busy
  // --------------------------------------------------------------------------
  // Grant FSM: arbitrate in IDLE, count beats while granted, release to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= REQ_IN1;
      beat_cnt_q   <= '0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          beat_cnt_q <= '0;
          if (w_any_req) begin
            state_q <= (w_pick == REQ_IN1) ? ARB_GRANT1 : ARB_GRANT0;
            sel_q   <= (w_pick == REQ_IN1);
            busy_q  <= 1'b1;
          end
        end
        ARB_GRANT0, ARB_GRANT1: begin
          if (w_release) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= sel_q ? REQ_IN1 : REQ_IN0;
            beat_cnt_q   <= '0;
            sel_q        <= 1'b0;
            busy_q       <= 1'b0;
          end else if (w_xfer) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          beat_cnt_q <= '0;
          sel_q      <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  // Next output: load on transfer, drain when accepted, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_last_d  = w_xfer_last;
      out_data_d  = w_mux_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage registers; reset empties the stage and abandons any packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

endmodule : layer_input_arbiter
`default_nettype wire
